// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/LSU memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  // Requester indices into the 2-bit request/grant vectors.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic [3:0] STRB_FULL = 4'b1111;

  // Per-byte select: strobed bytes come from new_word, the rest from old_word.
  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer records which port was granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_data;

  // Single requester wins outright; on contention the port not granted last wins.
  always_comb begin
    grant = '0;
    if (req[PORT_FETCH] && req[PORT_DATA]) begin
      if (last_data) begin
        grant[PORT_FETCH] = 1'b1;
      end else begin
        grant[PORT_DATA] = 1'b1;
      end
    end else begin
      grant = req;
    end
  end

  // Pointer moves only when a request is actually accepted; resets to fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_data <= 1'b0;
    end else if (accept) begin
      last_data <= grant[PORT_DATA];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter in front of a single-port word RAM, with read-modify-write
// handling of sub-word stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 f_req,
  input  logic [MEM_DEPTH-1:0] f_addr,
  output logic                 f_ready,
  output logic                 f_rvalid,
  output logic [31:0]          f_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [3:0]           d_strb,
  input  logic [MEM_DEPTH-1:0] d_addr,
  input  logic [31:0]          d_wdata,
  output logic                 d_ready,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  output logic                 mem_we,
  output logic [MEM_DEPTH-1:0] mem_addr,
  output logic [31:0]          mem_d,
  input  logic [31:0]          mem_q
);

  state_t               state;
  logic [MEM_DEPTH-1:0] rmw_addr;
  logic [31:0]          rmw_wdata;
  logic [31:0]          rmw_q;
  logic [3:0]           rmw_strb;
  logic [1:0]           arb_req;
  logic [1:0]           grant;
  logic                 accept;
  logic                 d_full;
  logic                 d_none;

  // Requests are only visible to the arbiter in IDLE and out of reset, so
  // grant (and thus ready) is naturally zero during RMW_WR and reset.
  assign arb_req = (state == IDLE && !reset) ? {d_req, f_req} : 2'b00;
  assign accept  = |arb_req;
  assign f_ready = grant[PORT_FETCH];
  assign d_ready = grant[PORT_DATA];
  assign d_full  = (d_strb == STRB_FULL);
  assign d_none  = (d_strb == '0);

  rr_arb2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    (arb_req),
    .accept (accept),
    .grant  (grant)
  );

  // RAM port drive: merged write in RMW_WR, otherwise the granted request's address.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_d    = '0;
    if (state == RMW_WR) begin
      mem_we   = ~reset;
      mem_addr = rmw_addr;
      mem_d    = byte_merge(rmw_q, rmw_wdata, rmw_strb);
    end else if (f_ready) begin
      mem_addr = f_addr;
    end else if (d_ready) begin
      mem_addr = d_addr;
      if (d_we && d_full) begin
        mem_we = 1'b1;
        mem_d  = d_wdata;
      end
    end
  end

  // Control FSM with registered responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      rmw_addr  <= '0;
      rmw_wdata <= '0;
      rmw_q     <= '0;
      rmw_strb  <= '0;
    end else begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (f_ready) begin
            f_rvalid <= 1'b1;
            f_rdata  <= mem_q;
          end
          if (d_ready) begin
            if (!d_we) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_q;
            end else if (d_full || d_none) begin
              d_rvalid <= 1'b1;
              d_rdata  <= '0;
            end else begin
              rmw_addr  <= d_addr;
              rmw_wdata <= d_wdata;
              rmw_strb  <= d_strb;
              rmw_q     <= mem_q;
              state     <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          d_rvalid <= 1'b1;
          d_rdata  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: word RAM model, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned WORDS = 1 << (AW - 2);

  logic          clock;
  logic          reset;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ready;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_strb;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ready;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_d;
  logic [31:0]   mem_q;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MEM_DEPTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_ready  (f_ready),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_strb   (d_strb),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM macro: combinational read (0 while writing), posedge write.
  logic [31:0] ram [WORDS];
  assign mem_q = mem_we ? 32'h0 : ram[mem_addr[AW-1:2]];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[AW-1:2]] <= mem_d;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] shadow [WORDS];
  bit          m_merge;
  logic [15:0] m_maddr;
  logic [31:0] m_mval;
  bit          m_lastdata;
  bit          e_fv, e_dv, n_fv, n_dv;
  logic [31:0] e_fd, e_dd, n_fd, n_dd;
  bit          x_fr, x_dr, x_we, take_f, take_d;
  logic [15:0] x_addr;
  logic [31:0] x_d;
  logic [13:0] mw;

  initial begin
    e_fv = 0; e_dv = 0; e_fd = 0; e_dd = 0;
    m_merge = 0; m_lastdata = 0; m_maddr = 0; m_mval = 0;
    @(posedge clock);
    forever begin
      @(negedge clock);
      check("f_rvalid", {31'b0, f_rvalid}, {31'b0, e_fv});
      if (e_fv) check("f_rdata", f_rdata, e_fd);
      check("d_rvalid", {31'b0, d_rvalid}, {31'b0, e_dv});
      if (e_dv) check("d_rdata", d_rdata, e_dd);
      n_fv = 0; n_dv = 0; n_fd = 0; n_dd = 0;
      x_fr = 0; x_dr = 0; x_we = 0; x_addr = 0; x_d = 0;
      if (reset) begin
        m_merge    = 0;
        m_lastdata = 0;
      end else if (m_merge) begin
        x_we   = 1;
        x_addr = m_maddr;
        x_d    = m_mval;
        shadow[m_maddr[15:2]] = m_mval;
        n_dv    = 1;
        m_merge = 0;
      end else begin
        take_f = f_req && (!d_req || m_lastdata);
        take_d = d_req && !take_f;
        if (take_f) begin
          x_fr = 1; x_addr = f_addr; m_lastdata = 0;
          n_fv = 1; n_fd = shadow[f_addr[15:2]];
        end
        if (take_d) begin
          x_dr = 1; x_addr = d_addr; m_lastdata = 1;
          mw = d_addr[15:2];
          if (!d_we) begin
            n_dv = 1; n_dd = shadow[mw];
          end else if (d_strb == 4'hF) begin
            x_we = 1; x_d = d_wdata; shadow[mw] = d_wdata; n_dv = 1;
          end else if (d_strb == 4'h0) begin
            n_dv = 1;
          end else begin
            m_merge = 1;
            m_maddr = d_addr;
            for (int b = 0; b < 4; b++)
              m_mval[8*b +: 8] = d_strb[b] ? d_wdata[8*b +: 8] : shadow[mw][8*b +: 8];
          end
        end
      end
      check("f_ready", {31'b0, f_ready}, {31'b0, x_fr});
      check("d_ready", {31'b0, d_ready}, {31'b0, x_dr});
      check("mem_we", {31'b0, mem_we}, {31'b0, x_we});
      if (!reset) check("mem_addr", {16'b0, mem_addr}, {16'b0, x_addr});
      if (x_we) check("mem_d", mem_d, x_d);
      e_fv = n_fv; e_fd = n_fd; e_dv = n_dv; e_dd = n_dd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic data_op(input logic we, input logic [3:0] strb,
                         input logic [15:0] addr, input logic [31:0] wdata);
    int k;
    d_req = 1; d_we = we; d_strb = strb; d_addr = addr; d_wdata = wdata;
    k = 0;
    @(negedge clock);
    while (!d_ready && k < 8) begin
      @(negedge clock);
      k++;
    end
    check("d_ready_wait", {31'b0, d_ready}, 32'd1);
    next_cycle();
    d_req = 0;
  endtask

  initial begin
    reset = 1; f_req = 0; f_addr = 0;
    d_req = 0; d_we = 0; d_strb = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < int'(WORDS); i++) begin
      ram[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    ram[16'h0010 >> 2] = 32'hDEADBEEF; shadow[16'h0010 >> 2] = 32'hDEADBEEF;
    ram[16'h0020 >> 2] = 32'hCAFEF00D; shadow[16'h0020 >> 2] = 32'hCAFEF00D;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;

    // 1: single fetch
    f_req = 1; f_addr = 16'h0010;
    @(negedge clock); check("t1_f_ready", {31'b0, f_ready}, 32'd1);
    next_cycle(); f_req = 0;
    @(negedge clock);
    check("t1_f_rvalid", {31'b0, f_rvalid}, 32'd1);
    check("t1_f_rdata", f_rdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clock); check("t1_f_rvalid_low", {31'b0, f_rvalid}, 32'd0);
    next_cycle();

    // 2: contention, grants alternate D,F,D,F
    f_req = 1; f_addr = 16'h0010;
    d_req = 1; d_we = 0; d_addr = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("t2_d_ready%0d", i), {31'b0, d_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_f_ready%0d", i), {31'b0, f_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      next_cycle();
    end
    f_req = 0; d_req = 0;
    next_cycle();

    // 3: full store, then load of the same word the very next cycle
    d_req = 1; d_we = 1; d_strb = 4'hF; d_addr = 16'h0020; d_wdata = 32'h12345678;
    @(negedge clock); check("t3_mem_we", {31'b0, mem_we}, 32'd1);
    next_cycle(); d_we = 0;
    @(negedge clock);
    check("t3_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("t3_store_rdata", d_rdata, 32'h0);
    next_cycle(); d_req = 0;
    @(negedge clock); check("t3_load_rdata", d_rdata, 32'h12345678);
    next_cycle();

    // 4: partial store with a fetch arriving behind it
    d_req = 1; d_we = 1; d_strb = 4'b0101; d_addr = 16'h0020; d_wdata = 32'hAABBCCDD;
    @(negedge clock); check("t4_acc_we", {31'b0, mem_we}, 32'd0);
    next_cycle(); d_req = 0; f_req = 1; f_addr = 16'h0020;
    @(negedge clock);
    check("t4_rmw_we", {31'b0, mem_we}, 32'd1);
    check("t4_rmw_d", mem_d, 32'h12BB56DD);
    check("t4_f_stall", {31'b0, f_ready}, 32'd0);
    next_cycle();
    @(negedge clock);
    check("t4_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("t4_f_ready", {31'b0, f_ready}, 32'd1);
    next_cycle(); f_req = 0;
    @(negedge clock); check("t4_f_rdata", f_rdata, 32'h12BB56DD);
    next_cycle();

    // 5: zero-strobe store
    d_req = 1; d_we = 1; d_strb = 4'h0; d_addr = 16'h0020; d_wdata = 32'hFFFFFFFF;
    @(negedge clock); check("t5_mem_we", {31'b0, mem_we}, 32'd0);
    next_cycle(); d_req = 0;
    @(negedge clock); check("t5_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    next_cycle(); d_req = 1; d_we = 0;
    @(negedge clock);
    next_cycle(); d_req = 0;
    @(negedge clock); check("t5_unchanged", d_rdata, 32'h12BB56DD);
    next_cycle();

    // 6: reset lands on the RMW_WR cycle
    d_req = 1; d_we = 1; d_strb = 4'b0011; d_addr = 16'h0020; d_wdata = 32'h0;
    @(negedge clock); check("t6_accept", {31'b0, d_ready}, 32'd1);
    next_cycle(); d_req = 0; reset = 1;
    @(negedge clock); check("t6_we_suppressed", {31'b0, mem_we}, 32'd0);
    next_cycle(); reset = 0; d_req = 1; d_we = 0; d_addr = 16'h0020;
    @(negedge clock);
    check("t6_fresh_ready", {31'b0, d_ready}, 32'd1);
    check("t6_no_rvalid", {31'b0, d_rvalid}, 32'd0);
    next_cycle(); d_req = 0;
    @(negedge clock);
    check("t6_rdata", d_rdata, 32'h12BB56DD);
    check("t6_ram_word", ram[16'h0020 >> 2], 32'h12BB56DD);
    next_cycle();

    // 7: mixed data traffic against a held fetch, including top-of-memory words
    f_req = 1; f_addr = 16'hFFFD;
    data_op(1'b1, 4'hF,    16'hFFFC, 32'h11112222);
    data_op(1'b0, 4'h0,    16'hFFFE, 32'h0);
    data_op(1'b1, 4'b1000, 16'hFFFF, 32'h99000000);
    data_op(1'b1, 4'b0110, 16'h0012, 32'h55AA55AA);
    data_op(1'b0, 4'h0,    16'h0010, 32'h0);
    data_op(1'b1, 4'b0001, 16'h0000, 32'h00000077);
    data_op(1'b0, 4'h0,    16'h0003, 32'h0);
    f_req = 0;
    repeat (3) next_cycle();
    check("t7_top_word", ram[16'hFFFC >> 2], 32'h99112222);
    check("t7_merge_word", ram[16'h0010 >> 2], 32'hDEAA55EF);
    check("t7_low_word", ram[0], 32'h00000077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one byte-addressable, single-port, word-wide data RAM between two requesters: instruction fetch (read-only) and load/store (read/write with byte strobes).
- Performs round-robin arbitration with a valid/ready request handshake and registered responses.
- Implements sub-word stores by a two-cycle read-modify-write sequence.
- Sits between the core's fetch/LSU stages and the RAM macro; the RAM has a combinational read port that returns 0 while its write enable is high, and a posedge write.

Parameters:
- MEM_DEPTH, 16, byte-address width of the RAM and of all address ports.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch request valid
- f_addr  in  MEM_DEPTH  fetch byte address; bits [1:0] ignored
- f_ready  out  1  fetch request accepted this cycle (f_req && f_ready)
- f_rvalid  out  1  fetch response valid, one-cycle pulse
- f_rdata  out  32  fetch read data, registered
- d_req  in  1  data request valid
- d_we  in  1  1 = store, 0 = load
- d_strb  in  4  store byte enables; bit i enables wdata[8i+7:8i]
- d_addr  in  MEM_DEPTH  data byte address; bits [1:0] ignored
- d_wdata  in  32  store data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (load data or store completion), one-cycle pulse
- d_rdata  out  32  load data, registered; 0 for store responses
- mem_we  out  1  RAM write enable
- mem_addr  out  MEM_DEPTH  RAM byte address
- mem_d  out  32  RAM write data
- mem_q  in  32  RAM combinational read data

Behaviour:
- States: IDLE, RMW_WR.
- Reset values: state IDLE, f_rvalid = d_rvalid = 0, f_rdata = d_rdata = 0, rr pointer = FETCH (so data wins the first contention).
- While reset is high, mem_we = 0 and f_ready = d_ready = 0.

IDLE:
- Grant is combinational.
  - Only one port requesting: it is granted.
  - Both requesting: the port not granted last wins.
- The rr pointer updates only on an accepted request.
- Granted ready = 1, other ready = 0.
- Fetch accept: mem_we = 0, mem_addr = f_addr. mem_q is latched into f_rdata; f_rvalid = 1 the next cycle.
- Load accept: same as fetch, via d_rdata/d_rvalid.
- Store with d_strb = 4'b1111: mem_we = 1, mem_addr = d_addr, mem_d = d_wdata. d_rvalid = 1 the next cycle with d_rdata = 0.
- Store with d_strb = 4'b0000: no RAM write (mem_we = 0). Acknowledged like a full store; the RAM is unchanged.
- Store with partial strobe:
  - Accept cycle: mem_we = 0, mem_addr = d_addr.
  - Latch mem_q, address, wdata and strb; go to RMW_WR.
- When idle: mem_we = 0, mem_addr = 0, mem_d = 0.

RMW_WR (exactly one cycle):
- mem_we = 1, mem_addr = latched address.
- mem_d byte i = strb[i] ? wdata byte i : latched q byte i.
- f_ready = d_ready = 0 (requests stall and hold).
- Return to IDLE; d_rvalid = 1 the next cycle.

Timing:
- Latency: request accepted at cycle N gives the response at N+1; a partial store's response comes at N+2.
- Back-to-back accepts are allowed every IDLE cycle. Responses have no backpressure.

Boundaries and hazards:
- Reset asserted in RMW_WR: the merged write is suppressed (mem_we forced 0), state returns to IDLE, and no response is issued.
- A read accepted the cycle after a store to the same word sees the new data, since the RAM write lands on the accept edge.
- Addresses wrap naturally within MEM_DEPTH bits; no range check is done.
- Requesters must hold req and payload stable until ready.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, RMW_WR}
  - port index constants PORT_FETCH = 0, PORT_DATA = 1
  - STRB_FULL = 4'b1111
  - function byte_merge(old, new, strb) returning 32 bits
- One sub-module is natural: rr_arb2 (2-way round-robin, inputs req[1:0] and accept, output grant[1:0], pointer register inside).

Test Plan:
1. After reset, with the RAM preloaded at word 0x0010 with 0xDEADBEEF: f_req with f_addr = 0x0010 -> f_ready = 1 the same cycle; next cycle f_rvalid = 1, f_rdata = 0xDEADBEEF; the following cycle f_rvalid = 0.
2. f_req and d_req (load) both held for 4 cycles -> grants D, F, D, F. Each response appears one cycle after its accept and only on the granted port's rvalid.
3. Full store d_addr = 0x0020, d_wdata = 0x12345678, strb = 1111 -> mem_we = 1 for one cycle and d_rvalid the next; a subsequent load returns 0x12345678.
4. Word 0x0020 = 0x12345678, store strb = 0101, wdata = 0xAABBCCDD -> cycle N: mem_we = 0; cycle N+1: mem_we = 1, mem_d = 0x12BB56DD, both readys 0; cycle N+2: d_rvalid = 1. A pending f_req is accepted at N+2, not earlier.
5. Store with strb = 0000 -> no mem_we pulse, d_rvalid next cycle, and the word is unchanged on a later read.
6. Partial store with reset asserted in the RMW_WR cycle -> mem_we stays 0, the RAM word is unchanged, no d_rvalid, and the state is IDLE afterwards (a fresh load is accepted immediately).
